lgn_pattern_sequencer: RTL
==========================

// Module: lgn_pattern_sequencer
// PURPOSE
//  Multi-image stimulus/capture sequencer for the LGN MNIST classifier on the FPGA board.
//  - Holds NUM_PATTERNS images and their expected labels in ROM.
//  - Streams the selected image into the classifier byte-by-byte, repeating continuously.
//  - Latches the returned class index after a fixed pipeline latency and flags label match.
//  - A debounced button steps through the images.
//  - Sits between board I/O and the classifier; class_idx feeds the seven-segment decoder.
// PARAMETERS
//  BYTE_W           8           width of one streamed image byte
//  BYTES_PER_IMAGE  32          bytes per image frame (>=1)
//  NUM_PATTERNS     4           images in ROM (>=1); SEL_W = max(1, $clog2(NUM_PATTERNS))
//  LATENCY          4           cycles from last byte out to class result valid at DUT (>=1)
//  CLASS_W          4           width of class index
//  DEBOUNCE_CYCLES  120000      stable cycles required before a button level is accepted
//  AUTO_PERIOD      12000000    cycles between automatic advances (AUTO_ADVANCE_EN only)
//  IMG_FILE         "img.mem"   $readmemb image bytes: pattern p, byte k at p*BYTES_PER_IMAGE+k
//  LBL_FILE         "lbl.mem"   $readmemh expected labels, one per pattern
// PORTS
//  clk           in   1        system clock
//  rst_n         in   1        asynchronous active-low reset
//  btn_next      in   1        raw (bouncing) advance button, active-high
//  dut_class     in   CLASS_W  class index from classifier
//  dut_data      out  BYTE_W   image byte to classifier ui_in
//  dut_sof       out  1        high on the cycle dut_data carries byte 0
//  class_idx     out  CLASS_W  latched class result
//  class_valid   out  1        at least one capture done since reset/advance
//  label_match   out  1        class_idx == expected label of pattern_sel (0 when !class_valid)
//  pattern_sel   out  SEL_W    currently displayed pattern number
// BEHAVIOUR
//  Reset: single clk, rst_n asynchronous active-low.
//  - All registers clear asynchronously: state=STREAM, byte_cnt=0, outputs all 0, pattern_sel=0.
//  - The debouncer and auto-advance timer also clear.
//  - Reset mid-frame aborts the frame; no capture occurs.
//  FSM:
//  - STREAM: runs BYTES_PER_IMAGE cycles.
//    - dut_data <= ROM[pattern_sel*BYTES_PER_IMAGE + byte_cnt], registered, so byte k appears
//      the cycle after byte_cnt==k.
//    - dut_sof is asserted with byte 0.
//    - After byte_cnt==BYTES_PER_IMAGE-1 -> WAIT.
//  - WAIT: dut_data=0, counts LATENCY cycles, then -> CAPTURE.
//  - CAPTURE: one cycle.
//    - class_idx <= dut_class; class_valid <= 1.
//    - label_match <= (dut_class == LBL[pattern_sel]).
//    - -> STREAM with byte_cnt=0.
//  - Frame period = BYTES_PER_IMAGE+LATENCY+1 cycles. Frames repeat back-to-back indefinitely.
//  Debounce:
//  - Two-flop synchroniser on btn_next.
//  - The accepted level changes only after DEBOUNCE_CYCLES consecutive cycles of the new level.
//  - An advance request is raised on the accepted rising edge only; holding the button gives one
//    advance.
//  Advance:
//  - A request is held pending and applied only at a frame boundary (the CAPTURE->STREAM
//    transition).
//  - pattern_sel wraps NUM_PATTERNS-1 -> 0.
//  - On the same edge class_valid and label_match clear to 0; class_idx holds its old value.
//    This capture's result is discarded, so only results of the new pattern are shown.
//  - Multiple requests within one frame coalesce into one advance.
//  - If a request arrives in the same cycle as CAPTURE, it is applied at that boundary.
//  Arithmetic:
//  - ROM address width = $clog2(NUM_PATTERNS*BYTES_PER_IMAGE).
//  - Counters are sized to hold their max value; no overflow.
// CONFIGURATION
//  AUTO_ADVANCE_EN defined:
//  - A free-running counter raises an advance request every AUTO_PERIOD cycles.
//  - It is OR'd with the button request and follows the same boundary rule.
//  - A button advance restarts the timer.
//  AUTO_ADVANCE_EN undefined:
//  - No timer logic; the only advance source is btn_next.
// TESTING (BYTES_PER_IMAGE=4, NUM_PATTERNS=3, LATENCY=2, DEBOUNCE_CYCLES=3)
//  1. Release reset, images 0..2 loaded -> dut_sof every 7 cycles; dut_data walks img0 bytes
//     0..3 then 0,0,0; class_valid=0 until first CAPTURE.
//  2. dut_class=5, LBL[0]=5 -> after CAPTURE: class_idx=5, class_valid=1, label_match=1;
//     dut_class=3 next frame -> label_match=0.
//  3. btn_next bounces 1,0,1 then holds high 10 cycles -> exactly one advance, pattern_sel=1 at
//     the next frame boundary, class_valid drops for one frame.
//  4. Three accepted presses from sel=2 -> pattern_sel wraps to 0 after the first; the
//     remaining presses each advance on later frames.
//  5. Assert rst_n low during WAIT -> all outputs 0 immediately (async), no capture; restart
//     streams pattern 0 byte 0.
//  6. AUTO_ADVANCE_EN with AUTO_PERIOD=20, button idle -> pattern_sel steps 0,1,2,0 at frame
//     boundaries after each 20-cycle tick.

Source files
------------

// File: rtl/lgn_pattern_sequencer_if.sv
// lgn_pattern_sequencer_if: classifier-side link, image bytes and frame start out, class index back
interface lgn_pattern_sequencer_if #(
    parameter int BYTE_W  = 8,
    parameter int CLASS_W = 4
);
    logic [BYTE_W-1:0]  dut_data;
    logic               dut_sof;
    logic [CLASS_W-1:0] dut_class;

    modport master (output dut_data, output dut_sof, input dut_class);
    modport slave  (input dut_data, input dut_sof, output dut_class);
endinterface

// File: rtl/lgn_pattern_sequencer.sv
// lgn_pattern_sequencer: streams ROM images into the LGN classifier, captures the class, button/auto advance.
// Optional feature macro: AUTO_ADVANCE_EN adds a periodic advance timer (AUTO_PERIOD cycles).
// Image bytes and labels are elaboration-time constants: IMG_INIT holds pattern p, byte k at
// byte slot p*BYTES_PER_IMAGE+k; LBL_INIT holds the label of pattern p at slot p.
module lgn_pattern_sequencer #(
    parameter int BYTE_W          = 8,
    parameter int BYTES_PER_IMAGE = 32,
    parameter int NUM_PATTERNS    = 4,
    parameter int LATENCY         = 4,
    parameter int CLASS_W         = 4,
    parameter int DEBOUNCE_CYCLES = 120000,
`ifdef AUTO_ADVANCE_EN
    parameter int AUTO_PERIOD     = 12000000,
`endif
    parameter logic [NUM_PATTERNS*BYTES_PER_IMAGE*BYTE_W-1:0] IMG_INIT = '0,
    parameter logic [NUM_PATTERNS*CLASS_W-1:0]                LBL_INIT = '0,
    localparam int SEL_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   btn_next,
    lgn_pattern_sequencer_if.master bus,
    output logic [CLASS_W-1:0]     class_idx,
    output logic                   class_valid,
    output logic                   label_match,
    output logic [SEL_W-1:0]       pattern_sel
);
    localparam int ROM_N  = NUM_PATTERNS * BYTES_PER_IMAGE;
    localparam int AW     = (ROM_N > 1) ? $clog2(ROM_N) : 1;
    localparam int CNT_MX = (BYTES_PER_IMAGE > LATENCY) ? BYTES_PER_IMAGE : LATENCY;
    localparam int CNT_W  = $clog2(CNT_MX + 1);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_B   = CNT_W'(BYTES_PER_IMAGE - 1);
    localparam logic [CNT_W-1:0] LAST_L   = CNT_W'(LATENCY - 1);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_PATTERNS - 1);

    typedef enum logic [1:0] {ST_STREAM, ST_WAIT, ST_CAPTURE} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [BYTE_W-1:0]  r_data;
    logic               r_sof;
    logic [CLASS_W-1:0] r_class;
    logic               r_valid;
    logic               r_match;
    logic [SEL_W-1:0]   r_sel;
    logic               r_pend;
    logic               r_s1;
    logic               r_s2;
    logic               r_level;
    logic               r_btn_req;
    logic [DB_W-1:0]    r_db_cnt;

    logic [BYTE_W-1:0]  w_img [ROM_N];
    logic [CLASS_W-1:0] w_lbl_rom [NUM_PATTERNS];
    logic [AW-1:0]      w_addr;
    logic [CLASS_W-1:0] w_lbl;
    logic               w_req;

    for (genvar g = 0; g < ROM_N; g++) begin : g_img
        assign w_img[g] = IMG_INIT[g*BYTE_W +: BYTE_W];
    end

    for (genvar g = 0; g < NUM_PATTERNS; g++) begin : g_lbl
        assign w_lbl_rom[g] = LBL_INIT[g*CLASS_W +: CLASS_W];
    end

    assign w_addr = AW'(int'(r_sel) * BYTES_PER_IMAGE + int'(r_cnt));
    assign w_lbl  = w_lbl_rom[r_sel];

    // Synchronise the button, accept a level after DEBOUNCE_CYCLES stable cycles, pulse on accepted rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_level   <= 1'b0;
            r_btn_req <= 1'b0;
            r_db_cnt  <= '0;
        end else begin
            r_s1      <= btn_next;
            r_s2      <= r_s1;
            r_btn_req <= 1'b0;
            if (r_s2 == r_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_MAX) begin
                r_db_cnt  <= '0;
                r_level   <= r_s2;
                r_btn_req <= r_s2;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

`ifdef AUTO_ADVANCE_EN
    localparam int AP_W = $clog2(AUTO_PERIOD + 1);
    localparam logic [AP_W-1:0] AP_MAX = AP_W'(AUTO_PERIOD - 1);

    logic [AP_W-1:0] r_auto_cnt;
    logic            r_auto_req;

    // Free-running advance tick; a button advance restarts the period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_auto_cnt <= '0;
            r_auto_req <= 1'b0;
        end else begin
            r_auto_req <= 1'b0;
            if (r_btn_req) begin
                r_auto_cnt <= '0;
            end else if (r_auto_cnt == AP_MAX) begin
                r_auto_cnt <= '0;
                r_auto_req <= 1'b1;
            end else begin
                r_auto_cnt <= r_auto_cnt + 1'b1;
            end
        end
    end

    assign w_req = r_btn_req | r_auto_req;
`else
    assign w_req = r_btn_req;
`endif

    // Frame FSM: stream the image, wait out the classifier latency, capture or apply a pending advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_STREAM;
            r_cnt   <= '0;
            r_data  <= '0;
            r_sof   <= 1'b0;
            r_class <= '0;
            r_valid <= 1'b0;
            r_match <= 1'b0;
            r_sel   <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_data <= '0;
            r_sof  <= 1'b0;
            if (r_state != ST_CAPTURE)
                r_pend <= r_pend | w_req;
            case (r_state)
                ST_STREAM: begin
                    r_data <= w_img[w_addr];
                    r_sof  <= (r_cnt == '0);
                    if (r_cnt == LAST_B) begin
                        r_cnt   <= '0;
                        r_state <= ST_WAIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == LAST_L) begin
                        r_cnt   <= '0;
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    r_state <= ST_STREAM;
                    r_cnt   <= '0;
                    r_pend  <= 1'b0;
                    if (r_pend | w_req) begin
                        r_sel   <= (r_sel == LAST_SEL) ? '0 : r_sel + 1'b1;
                        r_valid <= 1'b0;
                        r_match <= 1'b0;
                    end else begin
                        r_class <= bus.dut_class;
                        r_valid <= 1'b1;
                        r_match <= (bus.dut_class == w_lbl);
                    end
                end
                default: r_state <= ST_STREAM;
            endcase
        end
    end

    assign bus.dut_data = r_data;
    assign bus.dut_sof  = r_sof;
    assign class_idx    = r_class;
    assign class_valid  = r_valid;
    assign label_match  = r_match;
    assign pattern_sel  = r_sel;
endmodule
